// File: rtl/red_pkg.sv
// red_pkg: shared definitions for the RED byte-reduction sequencer.
//   - red_state_e : sequencer state encoding (4-bit binary)
//   - RED_LAT     : start-to-done latency in cycles
//   - NIB_W       : width of the shared adder slice
package red_pkg;

  localparam int unsigned RED_LAT = 8;
  localparam int unsigned NIB_W   = 4;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LO0  = 4'd1,
    LO1  = 4'd2,
    HI0  = 4'd3,
    HI1  = 4'd4,
    S0   = 4'd5,
    S1   = 4'd6,
    S2   = 4'd7,
    DONE = 4'd8
  } red_state_e;

endpackage

// File: rtl/adder_4bit.sv
// adder_4bit: nibble ripple slice.
//   A, B : 4-bit addends
//   C    : carry-in
//   Sum  : 4-bit sum
//   Cout : carry-out
module adder_4bit
  import red_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             C,
  output logic [NIB_W-1:0] Sum,
  output logic             Cout
);

  always_comb begin
    {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{NIB_W{1'b0}}, C};
  end

endmodule

// File: rtl/red_seq.sv
// red_seq: multi-cycle signed byte-reduction coprocessor.
//   result = sext16( s8(A[7:0]) + s8(B[7:0]) + s8(A[15:8]) + s8(B[15:8]) )
// computed one nibble per cycle through a single shared adder_4bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only in IDLE
//   A, B       : operands, captured on an accepted start
//   busy       : high while working (LO0..S2)
//   done       : one-cycle pulse, result valid from this cycle on
//   result     : sign-extended reduction result, held until next done
module red_seq
  import red_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  red_state_e        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              carry_q, carry_d;
  logic [8:0]        sl_q, sl_d;
  logic [8:0]        sh_q, sh_d;
  logic [9:0]        r_q, r_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [NIB_W-1:0]  add_x, add_y, add_sum;
  logic              add_c, add_cout;

  adder_4bit u_adder (
    .A    (add_x),
    .B    (add_y),
    .C    (add_c),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  // Operand mux for the shared slice; the first nibble of each sum starts
  // with carry-in 0 regardless of the carry register.
  always_comb begin
    add_x = '0;
    add_y = '0;
    add_c = 1'b0;
    case (state_q)
      LO0: begin add_x = a_q[3:0];   add_y = b_q[3:0];                   end
      LO1: begin add_x = a_q[7:4];   add_y = b_q[7:4];   add_c = carry_q; end
      HI0: begin add_x = a_q[11:8];  add_y = b_q[11:8];                  end
      HI1: begin add_x = a_q[15:12]; add_y = b_q[15:12]; add_c = carry_q; end
      S0:  begin add_x = sl_q[3:0];  add_y = sh_q[3:0];                  end
      S1:  begin add_x = sl_q[7:4];  add_y = sh_q[7:4];  add_c = carry_q; end
      S2:  begin
        add_x = {NIB_W{sl_q[8]}};
        add_y = {NIB_W{sh_q[8]}};
        add_c = carry_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    sl_d     = sl_q;
    sh_d     = sh_q;
    r_d      = r_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = 1'b0;
          state_d = LO0;
        end
      end
      LO0: begin
        sl_d[3:0] = add_sum;
        carry_d   = add_cout;
        state_d   = LO1;
      end
      LO1: begin
        // Bit 8 of the 9-bit signed byte sum is sign(A)^sign(B)^carry-out.
        sl_d[7:4] = add_sum;
        sl_d[8]   = a_q[7] ^ b_q[7] ^ add_cout;
        carry_d   = add_cout;
        state_d   = HI0;
      end
      HI0: begin
        sh_d[3:0] = add_sum;
        carry_d   = add_cout;
        state_d   = HI1;
      end
      HI1: begin
        sh_d[7:4] = add_sum;
        sh_d[8]   = a_q[15] ^ b_q[15] ^ add_cout;
        carry_d   = add_cout;
        state_d   = S0;
      end
      S0: begin
        r_d[3:0] = add_sum;
        carry_d  = add_cout;
        state_d  = S1;
      end
      S1: begin
        r_d[7:4] = add_sum;
        carry_d  = add_cout;
        state_d  = S2;
      end
      S2: begin
        // Top bits are loaded into result on the same edge that enters
        // DONE, so result is already valid while done is high.
        r_d[9:8] = add_sum[1:0];
        carry_d  = add_cout;
        result_d = {{(DATA_W-10){add_sum[1]}}, add_sum[1:0], r_q[7:0]};
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d inside {LO0, LO1, HI0, HI1, S0, S1, S2});
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      sl_q     <= '0;
      sh_q     <= '0;
      r_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      sl_q     <= sl_d;
      sh_q     <= sh_d;
      r_q      <= r_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/red_seq.md
# red_seq

Multi-cycle sequencer for the RED (byte-reduction) operation in the logic-unit datapath. It computes the signed sum of the four bytes of operands A and B using a single shared `adder_4bit` nibble slice and a carry register, one nibble step per cycle. It sits beside the ALU as a start/done coprocessor, so the processor stalls while `busy` is high.

## Interface
- `DATA_W`, default 16: operand and result width. Only the value 16 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  16  operand A; captured on an accepted start.
- `B`  in  16  operand B; captured on an accepted start.
- `busy`  out  1  high while a reduction is in progress (states LO0..S2).
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle on.
- `result`  out  16  sign-extended reduction result.

## Operation
- Function: treat each byte as signed 8-bit.
  - SL = A[7:0] + B[7:0], 9-bit signed.
  - SH = A[15:8] + B[15:8], 9-bit signed.
  - R = SL + SH, 10-bit signed.
  - `result` = R sign-extended to 16 bits.
- State machine: IDLE → LO0 → LO1 → HI0 → HI1 → S0 → S1 → S2 → DONE → IDLE.
- IDLE: when `start`=1, latch A and B into internal registers, clear carry, go to LO0. Otherwise stay in IDLE.
- Each working state drives the one shared adder slice (operand nibble X, operand nibble Y, carry-in = carry register). It registers the 4-bit sum into the named field and registers Cout into the carry register.
  - LO0: A[3:0]+B[3:0], cin=0 → SL[3:0].
  - LO1: A[7:4]+B[7:4] → SL[7:4]. Also SL[8] = A[7]^B[7]^Cout.
  - HI0: A[11:8]+B[11:8], cin forced 0 → SH[3:0].
  - HI1: A[15:12]+B[15:12] → SH[7:4]. Also SH[8] = A[15]^B[15]^Cout.
  - S0: SL[3:0]+SH[3:0], cin=0 → R[3:0].
  - S1: SL[7:4]+SH[7:4] → R[7:4].
  - S2: {4{SL[8]}} + {4{SH[8]}} with carry-in from S1. Sum bits [1:0] → R[9:8].
- DONE: load `result` = {{6{R[9]}}, R[9:0]}, assert `done`, return to IDLE.
- `result` holds its value until the next DONE. It is not cleared by a new start.
- `start` is ignored in every state other than IDLE, including DONE. A and B may change freely after acceptance.
- Overflow cannot occur: the range is −512..+508, which fits in 10 bits.

## Timing
- Reset (async, rst_n=0): state=IDLE, `busy`=0, `done`=0, `result`=0x0000, carry=0, internal fields=0.
- Reset asserted mid-operation aborts immediately. No `done` is produced, and the aborted operation's partial result is never loaded.
- Latency: if `start` is sampled at edge k, then `busy`=1 for cycles k+1..k+7 and `done`=1 for cycle k+8 only.
- `result` changes only at the edge that enters DONE. It is stable from that cycle onward.
- Back-to-back: a new `start` can be accepted at the first edge after DONE. The throughput is one operation per 9 cycles.
- `busy` and `done` are registered and are never high at the same time.

## Structure
- Shared package/header `red_pkg` contains:
  - the state encoding constants (IDLE, LO0, LO1, HI0, HI1, S0, S1, S2, DONE; 4-bit binary);
  - the constants `RED_LAT`=8 and `NIB_W`=4.
- Sub-module: exactly one instance of the existing `adder_4bit` (ports A, B, C, Sum, Cout), fed through a state-indexed operand mux.
- All other logic lives in `red_seq`: the FSM, the operand/carry registers, and the SL/SH/R registers.

## Test plan
- Reset during LO1 with A=0x7F7F, B=0x7F7F → `busy` goes 0 asynchronously, no `done`, `result` stays 0x0000. A fresh start then completes normally.
- A=0x0102, B=0x0304 → `done` exactly 8 cycles after start, `result`=0x000A, `busy` high for 7 cycles.
- A=0x7F7F, B=0x7F7F → `result`=0x01FC (maximum positive, 508).
- A=0x8080, B=0x8080 → `result`=0xFE00 (−512, maximum negative). A=0xFF01, B=0x01FF → `result`=0x0000.
- `start` held high continuously with a new A/B each cycle → operations are accepted only in IDLE, one every 9 cycles. Each result matches the operands captured at acceptance, and start pulses during busy/DONE are ignored.
- Random signed A/B (≥10k ops) checked against the reference model sext16(sext9(A[7:0])+sext9(B[7:0])+sext9(A[15:8])+sext9(B[15:8])) → zero mismatches.
